mem_initiator: RTL and testbench

Initiator side of the multi-cycle `cs`/`we`/`ack` memory handshake used by the team's slow data RAM. It sits between a CPU- or cache-side request port and the RAM. Requests go into a small FIFO and are issued one at a time, with `mem_cs` held until `mem_ack`. A mandatory idle gap follows each transaction so the responder returns to idle, and the block returns one response per request.

---
 rtl/mem_initiator.sv | 155 +++++++++++++++
 tb/tb_mem_initiator.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// Initiator for the slow data RAM cs/we/ack handshake: request FIFO, one transaction at a time, mandatory idle gap.
// Optional ISSUE watchdog compiled in with `define MEM_INITIATOR_TIMEOUT_EN.
module mem_initiator #(
   parameter int QDEPTH_LOG2 = 1,
   parameter int TIMEOUT     = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_we,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout,
   input  logic        mem_ack
);

   localparam int DEPTH = 1 << QDEPTH_LOG2;
   localparam logic [QDEPTH_LOG2:0]   FULL_CNT = (QDEPTH_LOG2+1)'(DEPTH);
   localparam logic [QDEPTH_LOG2:0]   CNT_ONE  = (QDEPTH_LOG2+1)'(1);
   localparam logic [QDEPTH_LOG2-1:0] PTR_ONE  = QDEPTH_LOG2'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic                   fifo_we    [DEPTH];
   logic [31:0]            fifo_addr  [DEPTH];
   logic [31:0]            fifo_wdata [DEPTH];
   logic [QDEPTH_LOG2-1:0] wr_ptr;
   logic [QDEPTH_LOG2-1:0] rd_ptr;
   logic [QDEPTH_LOG2:0]   count;
   logic [1:0]             state;
   logic                   push;
   logic                   pop;

   // Ready comes from the registered count only, so a pop on a full cycle does not open a slot early.
   assign req_ready = (count != FULL_CNT);
   assign push      = req_valid && req_ready;
   assign pop       = (state == ST_IDLE) && (count != '0);
   assign busy      = (count != '0) || (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_we[wr_ptr]    <= req_we;
         fifo_addr[wr_ptr]  <= req_addr;
         fifo_wdata[wr_ptr] <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

`ifdef MEM_INITIATOR_TIMEOUT_EN
   logic [7:0] tmo_cnt;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
`else
   logic unused_timeout;
   assign unused_timeout = ^8'(TIMEOUT);
   assign resp_err       = 1'b0;
`endif

   // Transaction sequencer; mem_* fields stay stable from issue until the next pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         mem_cs     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         resp_valid <= 1'b0;
         resp_we    <= 1'b0;
         resp_rdata <= '0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
         resp_err   <= 1'b0;
         tmo_cnt    <= '0;
`endif
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  mem_cs   <= 1'b1;
                  mem_we   <= fifo_we[rd_ptr];
                  mem_addr <= fifo_addr[rd_ptr];
                  mem_din  <= fifo_we[rd_ptr] ? fifo_wdata[rd_ptr] : 32'd0;
                  state    <= ST_ISSUE;
`ifdef MEM_INITIATOR_TIMEOUT_EN
                  tmo_cnt  <= '0;
`endif
               end
            end
            ST_ISSUE: begin
               if (mem_ack) begin
                  mem_cs     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_we    <= mem_we;
                  resp_rdata <= mem_we ? 32'd0 : mem_dout;
`ifdef MEM_INITIATOR_TIMEOUT_EN
                  resp_err   <= 1'b0;
`endif
                  state      <= ST_GAP;
               end
`ifdef MEM_INITIATOR_TIMEOUT_EN
               // An ack on the limit edge is taken above, so the error only fires on a silent edge.
               else if (tmo_cnt == TMO_LAST) begin
                  mem_cs     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_we    <= mem_we;
                  resp_rdata <= 32'd0;
                  resp_err   <= 1'b1;
                  state      <= ST_GAP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            ST_GAP: begin
               state <= ST_IDLE;
            end
            default: begin
               state  <= ST_IDLE;
               mem_cs <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed testbench for mem_initiator against a 4-cycle RAM responder model.
// Build with MEM_INITIATOR_TIMEOUT_EN defined or not; the silent-responder test adapts.
module tb_mem_initiator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_we;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;
   logic        mem_cs;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout = '0;
   logic        mem_ack;

   logic        rsp_ack = 1'b0;
   logic        stray_ack = 1'b0;
   logic        silent = 1'b0;
   int          wait_cnt = 0;
   logic [31:0] ram [16];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic        mon_we [$];
   logic [31:0] mon_rd [$];

   assign mem_ack = rsp_ack | stray_ack;

   mem_initiator #(.QDEPTH_LOG2(1), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_we(resp_we), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .busy(busy),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Responder: acks 4 edges after first sampling cs high, RAM preloaded on reset.
   always @(posedge clk) begin
      if (rst) begin
         rsp_ack  <= 1'b0;
         wait_cnt <= 0;
         for (int i = 0; i < 16; i++) ram[i] <= 32'hA000_0000 + i;
         ram[4] <= 32'hDEAD_BEEF;
      end else if (rsp_ack) begin
         rsp_ack  <= 1'b0;
         wait_cnt <= 0;
      end else if (mem_cs && !silent) begin
         if (wait_cnt == 3) begin
            rsp_ack  <= 1'b1;
            wait_cnt <= 0;
            if (mem_we) ram[mem_addr[5:2]] <= mem_din;
            else mem_dout <= ram[mem_addr[5:2]];
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         mon_we.push_back(resp_we);
         mon_rd.push_back(resp_rdata);
      end
   end

   task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           output int acc);
      int n;
      logic ok;
      n = 0;
      req_we = we; req_addr = addr; req_wdata = data; req_valid = 1'b1;
      do begin
         ok = req_ready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 50);
      req_valid = 1'b0;
      acc = cyc;
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL push_accept addr=%h not accepted within %0d cycles", addr, n);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      checks++;
      if (busy) begin
         failures++;
         $display("[TB] FAIL wait_idle busy=%b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({mem_cs, mem_we, resp_valid, resp_we, resp_err, busy, req_ready} !== 7'b0000001) begin
         failures++;
         $display("[TB] FAIL reset_ctrl got cs/we/rv/rwe/err/busy/rdy=%b required 0000001",
                  {mem_cs, mem_we, resp_valid, resp_we, resp_err, busy, req_ready});
      end
      checks++;
      if ({mem_addr, mem_din, resp_rdata} !== 96'd0) begin
         failures++;
         $display("[TB] FAIL reset_data got addr=%h din=%h rdata=%h required all 0",
                  mem_addr, mem_din, resp_rdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      int acc, first_hi, hi_cnt, rv_at;
      logic [31:0] got_rd, got_addr;
      logic got_we;
      first_hi = -1; hi_cnt = 0; rv_at = -1; got_rd = '0; got_we = 1'b1; got_addr = '0;
      push_req(1'b0, 32'h0000_0010, 32'h5555_5555, acc);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (mem_cs) begin
            hi_cnt++;
            if (first_hi < 0) begin first_hi = k; got_addr = mem_addr; end
         end
         if (resp_valid) begin rv_at = k; got_rd = resp_rdata; got_we = resp_we; end
      end
      checks++;
      if (first_hi != 1) begin failures++; $display("[TB] FAIL rd_cs_rise got edge A+%0d required A+1", first_hi); end
      checks++;
      if (hi_cnt != 5) begin failures++; $display("[TB] FAIL rd_cs_len got %0d required 5", hi_cnt); end
      checks++;
      if (got_addr !== 32'h10) begin failures++; $display("[TB] FAIL rd_addr got %h required 00000010", got_addr); end
      checks++;
      if (rv_at != 6) begin failures++; $display("[TB] FAIL rd_resp_time got A+%0d required A+6", rv_at); end
      checks++;
      if (got_rd !== 32'hDEAD_BEEF || got_we !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rd_resp got rdata=%h we=%b required deadbeef 0", got_rd, got_we);
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      int acc, hi_runs, gap;
      logic prev;
      mon_we.delete(); mon_rd.delete();
      push_req(1'b1, 32'h0000_0020, 32'h1234_5678, acc);
      push_req(1'b0, 32'h0000_0020, 32'h0, acc);
      hi_runs = mem_cs ? 1 : 0; gap = 0; prev = mem_cs;
      checks++;
      if (mem_din !== 32'h1234_5678 || mem_we !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_wr_issue got din=%h we=%b required 12345678 1", mem_din, mem_we);
      end
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (mem_cs && !prev) hi_runs++;
         if (!mem_cs && hi_runs == 1) gap++;
         prev = mem_cs;
      end
      wait_idle();
      checks++;
      if (gap != 2) begin failures++; $display("[TB] FAIL b2b_cs_gap got %0d low cycles required 2", gap); end
      checks++;
      if (mon_we.size() != 2) begin
         failures++;
         $display("[TB] FAIL b2b_resp_count got %0d required 2", mon_we.size());
      end else begin
         checks++;
         if (mon_we[0] !== 1'b1 || mon_rd[0] !== 32'd0) begin
            failures++;
            $display("[TB] FAIL b2b_resp0 got we=%b rdata=%h required 1 00000000", mon_we[0], mon_rd[0]);
         end
         checks++;
         if (mon_we[1] !== 1'b0 || mon_rd[1] !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL b2b_resp1 got we=%b rdata=%h required 0 12345678", mon_we[1], mon_rd[1]);
         end
      end
   endtask

   task automatic test_burst();
      int a0, a1, a2, a3;
      logic rdy_full;
      logic [31:0] exp_rd [4];
      exp_rd[0] = 32'hA000_0001; exp_rd[1] = 32'hA000_0002;
      exp_rd[2] = 32'hA000_0003; exp_rd[3] = 32'hA000_0006;
      mon_we.delete(); mon_rd.delete();
      push_req(1'b0, 32'h04, 32'h0, a0);
      repeat (2) @(posedge clk);
      #1;
      push_req(1'b0, 32'h08, 32'h0, a1);
      push_req(1'b0, 32'h0C, 32'h0, a2);
      rdy_full = req_ready;
      push_req(1'b0, 32'h18, 32'h0, a3);
      wait_idle();
      checks++;
      if (a2 - a0 != 4 || rdy_full !== 1'b0) begin
         failures++;
         $display("[TB] FAIL burst_full got a2-a0=%0d ready=%b required 4 0", a2 - a0, rdy_full);
      end
      checks++;
      if (a3 - a0 != 9) begin failures++; $display("[TB] FAIL burst_third_accept got A0+%0d required A0+9", a3 - a0); end
      checks++;
      if (mon_rd.size() != 4) begin
         failures++;
         $display("[TB] FAIL burst_resp_count got %0d required 4", mon_rd.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (mon_rd[i] !== exp_rd[i]) begin
               failures++;
               $display("[TB] FAIL burst_resp%0d got %h required %h", i, mon_rd[i], exp_rd[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int acc, stray;
      mon_we.delete(); mon_rd.delete();
      push_req(1'b0, 32'h10, 32'h0, acc);
      push_req(1'b0, 32'h14, 32'h0, acc);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({mem_cs, busy, resp_valid, req_ready} !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL midrst got cs/busy/rv/rdy=%b required 0001", {mem_cs, busy, resp_valid, req_ready});
      end
      rst = 1'b0;
      stray = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (mem_cs || resp_valid) stray++;
      end
      checks++;
      if (stray != 0 || mon_rd.size() != 0) begin
         failures++;
         $display("[TB] FAIL midrst_drop got %0d active cycles %0d responses required 0 0", stray, mon_rd.size());
      end
   endtask

`ifdef MEM_INITIATOR_TIMEOUT_EN
   task automatic test_timeout();
      int acc, hi_cnt, n, extra;
      logic got_rv, got_err;
      logic [31:0] got_rd;
      silent = 1'b1; hi_cnt = 0; n = 0; got_rv = 1'b0; got_err = 1'b0; got_rd = 32'hFFFF_FFFF; extra = 0;
      push_req(1'b0, 32'h10, 32'h0, acc);
      while (!got_rv && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (mem_cs) hi_cnt++;
         if (resp_valid) begin got_rv = 1'b1; got_err = resp_err; got_rd = resp_rdata; end
      end
      checks++;
      if (!got_rv || got_err !== 1'b1 || got_rd !== 32'd0) begin
         failures++;
         $display("[TB] FAIL tmo_resp got rv=%b err=%b rdata=%h required 1 1 00000000", got_rv, got_err, got_rd);
      end
      checks++;
      if (hi_cnt != 15) begin failures++; $display("[TB] FAIL tmo_cs_len got %0d required 15", hi_cnt); end
      stray_ack = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      stray_ack = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (mem_cs || resp_valid) extra++;
         @(posedge clk); #1;
      end
      checks++;
      if (extra != 0) begin failures++; $display("[TB] FAIL tmo_stray_ack got %0d active cycles required 0", extra); end
      silent = 1'b0;
   endtask
`else
   task automatic test_no_timeout();
      int acc, hi_cnt, rv_cnt;
      silent = 1'b1; hi_cnt = 0; rv_cnt = 0;
      push_req(1'b0, 32'h10, 32'h0, acc);
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (mem_cs) hi_cnt++;
         if (resp_valid) rv_cnt++;
      end
      checks++;
      if (hi_cnt != 100 || rv_cnt != 0) begin
         failures++;
         $display("[TB] FAIL silent_hold got cs cycles=%0d resps=%0d required 100 0", hi_cnt, rv_cnt);
      end
      checks++;
      if (resp_err !== 1'b0) begin failures++; $display("[TB] FAIL silent_err got %b required 0", resp_err); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      silent = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_back_to_back();
      test_burst();
      test_reset_mid();
`ifdef MEM_INITIATOR_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
